// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory array.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 15
);
  // Port 0: core load/store path
  logic              p0_req;
  logic              p0_we;
  logic [1:0]        p0_size;
  logic              p0_uns;
  logic [31:0]       p0_addr;
  logic [31:0]       p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [31:0]       p0_rdata;
  logic              p0_err;
  // Port 1: debug/loader path
  logic              p1_req;
  logic              p1_we;
  logic [1:0]        p1_size;
  logic              p1_uns;
  logic [31:0]       p1_addr;
  logic [31:0]       p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [31:0]       p1_rdata;
  logic              p1_err;
  // Memory array side
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_size, p0_uns, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_size, p1_uns, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_size, p0_uns, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_size, p1_uns, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter with store lane steering, load extraction/extension
// and misaligned-access detection. Memory read latency is one cycle.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 15,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  logic        r_rr_ptr;       // 0: port 0 preferred, 1: port 1 preferred
  logic        r_ld_pend;      // load response due this cycle
  logic        r_tag_port;
  logic [1:0]  r_tag_size;
  logic        r_tag_uns;
  logic [1:0]  r_tag_off;
  logic        r_err_pend;     // misaligned response due this cycle
  logic        r_err_port;
  logic [31:0] r_p0_rdata;
  logic [31:0] r_p1_rdata;

  logic        w_p0_win;
  logic        w_p1_win;
  logic        w_any;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_uns;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_mis;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [15:0] w_lane;
  logic [31:0] w_ld_data;
  logic        w_p0_ld;
  logic        w_p1_ld;
  logic        w_p0_er;
  logic        w_p1_er;
  logic [31:0] w_p0_rdata;
  logic [31:0] w_p1_rdata;
  logic        w_unused_addr;

  // Grant selection; no grants while reset is asserted
  always_comb begin
    w_p0_win = 1'b0;
    w_p1_win = 1'b0;
    if (rst_n) begin
      if (FIXED_PRIO) begin
        w_p0_win = bus.p0_req;
      end else begin
        w_p0_win = bus.p0_req && (!r_rr_ptr || !bus.p1_req);
      end
      w_p1_win = bus.p1_req && !w_p0_win;
    end
  end

  assign w_any      = w_p0_win | w_p1_win;
  assign bus.p0_gnt = w_p0_win;
  assign bus.p1_gnt = w_p1_win;

  // Request fields of the winning port (port 0 when idle)
  always_comb begin
    w_we    = bus.p0_we;
    w_size  = bus.p0_size;
    w_uns   = bus.p0_uns;
    w_addr  = bus.p0_addr;
    w_wdata = bus.p0_wdata;
    if (w_p1_win) begin
      w_we    = bus.p1_we;
      w_size  = bus.p1_size;
      w_uns   = bus.p1_uns;
      w_addr  = bus.p1_addr;
      w_wdata = bus.p1_wdata;
    end
  end

  // Half needs addr[0]=0, word (size 10 or 11) needs addr[1:0]=0
  assign w_mis = ((w_size == 2'b01) && w_addr[0]) || (w_size[1] && (w_addr[1:0] != 2'b00));

  // Store byte enables and lane replication
  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = w_wdata;
    unique case (w_size)
      2'b00: begin
        w_st_be    = 4'b0001 << w_addr[1:0];
        w_st_wdata = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_st_be    = 4'b0011 << w_addr[1:0];
        w_st_wdata = {2{w_wdata[15:0]}};
      end
      default: begin
        w_st_be    = 4'b1111;
        w_st_wdata = w_wdata;
      end
    endcase
  end

  assign bus.mem_en    = w_any & ~w_mis;
  assign bus.mem_we    = w_any & ~w_mis & w_we;
  assign bus.mem_be    = (w_any & ~w_mis) ? (w_we ? w_st_be : 4'b1111) : 4'b0000;
  assign bus.mem_addr  = w_addr[ADDR_W+1:2];
  assign bus.mem_wdata = w_st_wdata;
  assign w_unused_addr = ^{w_addr[31:ADDR_W+2], w_uns};

  // Load lane extraction and extension from the registered tag
  always_comb begin
    w_lane    = 16'(bus.mem_rdata >> {r_tag_off, 3'b000});
    w_ld_data = bus.mem_rdata;
    unique case (r_tag_size)
      2'b00:   w_ld_data = r_tag_uns ? {24'h0, w_lane[7:0]}
                                     : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_ld_data = r_tag_uns ? {16'h0, w_lane}
                                     : {{16{w_lane[15]}}, w_lane};
      default: w_ld_data = bus.mem_rdata;
    endcase
  end

  assign w_p0_ld = r_ld_pend  & ~r_tag_port;
  assign w_p1_ld = r_ld_pend  &  r_tag_port;
  assign w_p0_er = r_err_pend & ~r_err_port;
  assign w_p1_er = r_err_pend &  r_err_port;

  // Response data: fresh load, zero on error, else hold the last value
  always_comb begin
    w_p0_rdata = r_p0_rdata;
    w_p1_rdata = r_p1_rdata;
    if (w_p0_ld)      w_p0_rdata = w_ld_data;
    else if (w_p0_er) w_p0_rdata = 32'h0;
    if (w_p1_ld)      w_p1_rdata = w_ld_data;
    else if (w_p1_er) w_p1_rdata = 32'h0;
  end

  assign bus.p0_rvalid = w_p0_ld | w_p0_er;
  assign bus.p1_rvalid = w_p1_ld | w_p1_er;
  assign bus.p0_err    = w_p0_er;
  assign bus.p1_err    = w_p1_er;
  assign bus.p0_rdata  = w_p0_rdata;
  assign bus.p1_rdata  = w_p1_rdata;

  // Round-robin pointer, pending-response flags, load tag and held read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= 1'b0;
      r_ld_pend  <= 1'b0;
      r_tag_port <= 1'b0;
      r_tag_size <= 2'b00;
      r_tag_uns  <= 1'b0;
      r_tag_off  <= 2'b00;
      r_err_pend <= 1'b0;
      r_err_port <= 1'b0;
      r_p0_rdata <= 32'h0;
      r_p1_rdata <= 32'h0;
    end else begin
      if (w_any) begin
        r_rr_ptr   <= w_p0_win;  // point at the non-winner
        r_err_port <= w_p1_win;
      end
      r_ld_pend  <= w_any & ~w_mis & ~w_we;
      r_err_pend <= w_any & w_mis;
      if (w_any && !w_mis && !w_we) begin
        r_tag_port <= w_p1_win;
        r_tag_size <= w_size;
        r_tag_uns  <= w_uns;
        r_tag_off  <= w_addr[1:0];
      end
      r_p0_rdata <= w_p0_rdata;
      r_p1_rdata <= w_p1_rdata;
    end
  end

endmodule
